// File: rtl/video_filter.sv
// Three-stage video filter: per-line one-pole horizontal low-pass per colour channel,
// followed by a quality-scaled edge-emphasis term, with a matched sideband delay line.
module video_filter #(
    parameter int Q_SHIFT = 6,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] h_count_in,
    input  logic [9:0]  v_count_in,
    input  logic        active_draw_in,
    input  logic [23:0] pixel_in,
    input  logic [9:0]  cutoff,
    input  logic [9:0]  quality,
    output logic [10:0] h_count_out,
    output logic [9:0]  v_count_out,
    output logic        active_draw_out,
    output logic [23:0] pixel_out
);

    logic [8:0] a_reg;
    logic [5:0] q_reg;
    logic [5:0] q2;

    logic [LATENCY-1:0][10:0] h_pipe;
    logic [LATENCY-1:0][9:0]  v_pipe;
    logic [LATENCY-1:0]       act_pipe;

    // Channel index 2 = R, 1 = G, 0 = B, matching the {R,G,B} bus layout.
    logic [2:0][7:0] pix1;
    logic [2:0][7:0] raw2;
    logic [2:0][7:0] s1;
    logic [2:0][7:0] prev;
    logic [2:0][7:0] s1_next;
    logic [2:0][7:0] y_next;

    logic signed [17:0] diff    [3];
    logic signed [17:0] lp_prod [3];
    logic signed [15:0] slope   [3];
    logic signed [15:0] res_prod[3];
    logic signed [15:0] res_sum [3];

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            diff[c]     = $signed({10'd0, pix1[c]}) - $signed({10'd0, s1[c]});
            lp_prod[c]  = diff[c] * $signed({9'd0, a_reg});
            s1_next[c]  = 8'($signed({10'd0, s1[c]}) + (lp_prod[c] >>> 8));

            slope[c]    = $signed({8'd0, s1[c]}) - $signed({8'd0, prev[c]});
            res_prod[c] = slope[c] * $signed({10'd0, q2});
            res_sum[c]  = $signed({8'd0, s1[c]}) + (res_prod[c] >>> Q_SHIFT);

            if (res_sum[c] < 0)
                y_next[c] = 8'd0;
            else if (res_sum[c] > 255)
                y_next[c] = 8'd255;
            else
                y_next[c] = res_sum[c][7:0];
        end
    end

    // Coefficients are sampled only on the first pixel of a frame so a control change never tears a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= 9'd256;
            q_reg <= 6'd0;
        end else if (h_count_in == 11'd0 && v_count_in == 10'd0) begin
            a_reg <= {1'b0, cutoff[9:2]} + 9'd1;
            q_reg <= quality[9:4];
        end
    end

    // NOTE: every pipeline and filter-state register is cleared by reset so outputs read 0 at once
    // and stale line state can never leak into the first pixels after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_pipe    <= '0;
            v_pipe    <= '0;
            act_pipe  <= '0;
            pix1      <= '0;
            raw2      <= '0;
            q2        <= '0;
            s1        <= '0;
            prev      <= '0;
            pixel_out <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage read the previous cycle's values,
            // which is what makes this a true pipeline rather than a chain of wires.
            h_pipe   <= {h_pipe[LATENCY-2:0], h_count_in};
            v_pipe   <= {v_pipe[LATENCY-2:0], v_count_in};
            act_pipe <= {act_pipe[LATENCY-2:0], active_draw_in};
            pix1     <= pixel_in;
            raw2     <= pix1;
            q2       <= q_reg;

            if (act_pipe[0]) begin
                if (h_pipe[0] == 11'd0) begin
                    s1   <= pix1;
                    prev <= pix1;
                end else begin
                    prev <= s1;
                    s1   <= s1_next;
                end
            end

            pixel_out <= act_pipe[1] ? y_next : raw2;
        end
    end

    assign h_count_out     = h_pipe[LATENCY-1];
    assign v_count_out     = v_pipe[LATENCY-1];
    assign active_draw_out = act_pipe[LATENCY-1];

endmodule
